// File: rtl/gemm_seq_pkg.sv
// Shared types and widths for the GEMM tile sequencer.
package gemm_seq_pkg;

  localparam int ADDR_W = 32;
  localparam int DIM_W  = 5;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_FETCH_A = 3'd2,
    S_FETCH_B = 3'd3,
    S_COMPUTE = 3'd4,
    S_STORE_C = 3'd5,
    S_DONE    = 3'd6
  } state_e;

  // Tile configuration that must survive past the LOAD cycle.
  typedef struct packed {
    logic [ADDR_W-1:0] b_addr;
    logic [ADDR_W-1:0] b_stride;
    logic [ADDR_W-1:0] c_addr;
    logic [DIM_W-1:0]  m;
    logic [DIM_W-1:0]  k;
    logic [DIM_W-1:0]  n;
    logic              store;
    logic              overwrite;
  } cfg_t;

endpackage

// File: rtl/gemm_addr_gen.sv
// Row address generator: base plus stride accumulated per accepted request.
module gemm_addr_gen
  import gemm_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic [DIM_W-1:0]  count_i,
  input  logic              adv_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [DIM_W-1:0]  remain_q, remain_d;

  // Next address/count: a load wins over an advance so a phase change can reuse the generator at once.
  always_comb begin
    addr_d   = addr_q;
    stride_d = stride_q;
    remain_d = remain_q;
    if (load_i) begin
      addr_d   = base_i;
      stride_d = stride_i;
      remain_d = count_i;
    end else if (adv_i && (remain_q != {DIM_W{1'b0}})) begin
      addr_d   = addr_q + stride_q;
      remain_d = remain_q - {{(DIM_W-1){1'b0}}, 1'b1};
    end else begin
      addr_d   = addr_q;
    end
  end

  // Generator state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= {ADDR_W{1'b0}};
      stride_q <= {ADDR_W{1'b0}};
      remain_q <= {DIM_W{1'b0}};
    end else begin
      addr_q   <= addr_d;
      stride_q <= stride_d;
      remain_q <= remain_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (remain_q == {{(DIM_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/gemm_tile_sequencer.sv
// Sequences one GEMM tile: pop config, fetch A/B rows, run the array, store C rows.
module gemm_tile_sequencer
  import gemm_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              conf_empty,
  input  logic [ADDR_W-1:0] tile_A_addr,
  input  logic [ADDR_W-1:0] tile_B_addr,
  input  logic [ADDR_W-1:0] tile_C_addr,
  input  logic [ADDR_W-1:0] tile_A_stride,
  input  logic [ADDR_W-1:0] tile_B_stride,
  input  logic [DIM_W-1:0]  msize,
  input  logic [DIM_W-1:0]  ksize,
  input  logic [DIM_W-1:0]  nsize,
  input  logic              store,
  input  logic              overwrite,
  output logic              read_all_buffers,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic              arr_start,
  output logic              arr_overwrite,
  output logic [DIM_W-1:0]  arr_nsize,
  input  logic              arr_done,
  output logic              busy,
  output logic              tile_done
);

  state_e            state_q, state_d;
  cfg_t              cfg_q, cfg_d;
  logic              arr_start_q, arr_start_d;
  logic              gen_load_s;
  logic [ADDR_W-1:0] gen_base_s;
  logic [ADDR_W-1:0] gen_stride_s;
  logic [DIM_W-1:0]  gen_count_s;
  logic              gen_last_s;
  logic              gen_adv_s;

  assign mem_req   = (state_q == S_FETCH_A) || (state_q == S_FETCH_B) || (state_q == S_STORE_C);
  assign gen_adv_s = mem_req && mem_ack;

  // Next-state logic; zero-sized phases are skipped by choosing the next phase at load time.
  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    gen_load_s   = 1'b0;
    gen_base_s   = {ADDR_W{1'b0}};
    gen_stride_s = {ADDR_W{1'b0}};
    gen_count_s  = {DIM_W{1'b0}};
    case (state_q)
      S_IDLE: begin
        if (!conf_empty) state_d = S_LOAD;
        else             state_d = S_IDLE;
      end
      S_LOAD: begin
        cfg_d.b_addr    = tile_B_addr;
        cfg_d.b_stride  = tile_B_stride;
        cfg_d.c_addr    = tile_C_addr;
        cfg_d.m         = msize;
        cfg_d.k         = ksize;
        cfg_d.n         = nsize;
        cfg_d.store     = store;
        cfg_d.overwrite = overwrite;
        if (msize != {DIM_W{1'b0}}) begin
          gen_load_s   = 1'b1;
          gen_base_s   = tile_A_addr;
          gen_stride_s = tile_A_stride;
          gen_count_s  = msize;
          state_d      = S_FETCH_A;
        end else if (ksize != {DIM_W{1'b0}}) begin
          gen_load_s   = 1'b1;
          gen_base_s   = tile_B_addr;
          gen_stride_s = tile_B_stride;
          gen_count_s  = ksize;
          state_d      = S_FETCH_B;
        end else begin
          state_d      = S_COMPUTE;
        end
      end
      S_FETCH_A: begin
        if (gen_adv_s && gen_last_s) begin
          if (cfg_q.k != {DIM_W{1'b0}}) begin
            gen_load_s   = 1'b1;
            gen_base_s   = cfg_q.b_addr;
            gen_stride_s = cfg_q.b_stride;
            gen_count_s  = cfg_q.k;
            state_d      = S_FETCH_B;
          end else begin
            state_d      = S_COMPUTE;
          end
        end else begin
          state_d = S_FETCH_A;
        end
      end
      S_FETCH_B: begin
        if (gen_adv_s && gen_last_s) state_d = S_COMPUTE;
        else                         state_d = S_FETCH_B;
      end
      S_COMPUTE: begin
        if (arr_done) begin
          if (cfg_q.store && (cfg_q.m != {DIM_W{1'b0}})) begin
            // C rows share the B row stride.
            gen_load_s   = 1'b1;
            gen_base_s   = cfg_q.c_addr;
            gen_stride_s = cfg_q.b_stride;
            gen_count_s  = cfg_q.m;
            state_d      = S_STORE_C;
          end else begin
            state_d      = S_DONE;
          end
        end else begin
          state_d = S_COMPUTE;
        end
      end
      S_STORE_C: begin
        if (gen_adv_s && gen_last_s) state_d = S_DONE;
        else                         state_d = S_STORE_C;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    arr_start_d = (state_d == S_COMPUTE) && (state_q != S_COMPUTE);
  end

  // State, latched configuration and start-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cfg_q       <= '0;
      arr_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      arr_start_q <= arr_start_d;
    end
  end

  gemm_addr_gen u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load_i   (gen_load_s),
    .base_i   (gen_base_s),
    .stride_i (gen_stride_s),
    .count_i  (gen_count_s),
    .adv_i    (gen_adv_s),
    .addr_o   (mem_addr),
    .last_o   (gen_last_s)
  );

  assign read_all_buffers = (state_q == S_LOAD);
  assign mem_we           = (state_q == S_STORE_C);
  assign arr_start        = arr_start_q;
  assign arr_overwrite    = cfg_q.overwrite;
  assign arr_nsize        = cfg_q.n;
  assign busy             = (state_q != S_IDLE);
  assign tile_done        = (state_q == S_DONE);

endmodule

// File: doc/gemm_tile_sequencer.md
GEMM_TILE_SEQUENCER -- requirements
Module: gemm_tile_sequencer

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-002 SHALL have ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- conf_empty  in  1  config FIFO empty
- tile_A_addr, tile_B_addr, tile_C_addr  in  32  tile base byte addresses (FWFT, valid when !conf_empty)
- tile_A_stride, tile_B_stride  in  32  row strides, bytes
- msize, ksize, nsize  in  5  tile dimensions
- store, overwrite  in  1  control bits
- read_all_buffers  out  1  config FIFO pop pulse
- mem_req  out  1  memory request
- mem_we  out  1  1=write (C store), 0=read
- mem_addr  out  32  request byte address
- mem_ack  in  1  request accepted
- arr_start  out  1  systolic array start pulse
- arr_overwrite  out  1  latched overwrite
- arr_nsize  out  5  latched nsize
- arr_done  in  1  array compute finished
- busy  out  1  not IDLE
- tile_done  out  1  one-cycle completion pulse

Function
REQ-003 SHALL implement FSM: IDLE, LOAD, FETCH_A, FETCH_B, COMPUTE, STORE_C, DONE.
REQ-004 IDLE -> LOAD when conf_empty=0; else stay.
REQ-005 LOAD SHALL assert read_all_buffers for exactly one cycle and latch all config inputs in that same cycle; next state FETCH_A.
REQ-006 FETCH_A SHALL issue msize reads, row i address = tile_A_addr + i*tile_A_stride, i=0..msize-1.
REQ-007 FETCH_B SHALL issue ksize reads, row j address = tile_B_addr + j*tile_B_stride.
REQ-008 STORE_C SHALL issue msize writes (mem_we=1), row i address = tile_C_addr + i*tile_B_stride; entered only if latched store=1, else COMPUTE -> DONE.
REQ-009 Handshake: mem_req and mem_addr held stable until the cycle mem_ack=1; index advances on ack; next request may start the following cycle; mem_req=0 in non-fetch/store states.
REQ-010 Final ack of a phase SHALL transition to next phase the following cycle.
REQ-011 Zero size: msize=0 SHALL skip FETCH_A and STORE_C; ksize=0 SHALL skip FETCH_B; no mem_req issued for skipped phases.
REQ-012 COMPUTE entry SHALL pulse arr_start one cycle; stay until arr_done=1; arr_done outside COMPUTE ignored.
REQ-013 DONE SHALL pulse tile_done one cycle, then IDLE; a new config pending SHALL then be popped without extra idle cycles beyond one IDLE cycle.
REQ-014 Address arithmetic SHALL be 32-bit modulo (wrap silently), computed by accumulation (base, then +stride per ack), no multiplier.
REQ-015 Config inputs SHALL be ignored outside LOAD; changes mid-tile have no effect.
REQ-016 busy=1 in all states except IDLE.
REQ-017 arr_overwrite and arr_nsize SHALL reflect latched values from LOAD until next LOAD.

Reset
REQ-018 On rst: state IDLE; read_all_buffers, mem_req, mem_we, arr_start, tile_done, busy = 0; mem_addr, arr_nsize = 0; arr_overwrite = 0; all latched config and counters = 0.
REQ-019 rst mid-operation SHALL abort immediately; outstanding request dropped; no tile_done.

Structure
REQ-020 Package gemm_seq_pkg SHALL hold state enum, ADDR_W=32, DIM_W=5.
REQ-021 One sub-module gemm_addr_gen SHALL provide accumulating address + row counter (load base/stride/count, advance on ack, last flag).

Verification
REQ-022 Config A=0x1000,strideA=0x40,m=3,k=2,B=0x2000,strideB=0x20,C=0x3000,store=1, ack every cycle -> reads 0x1000,0x1040,0x1080,0x2000,0x2020; arr_start once; after arr_done writes 0x3000,0x3020,0x3040; tile_done one pulse.
REQ-023 Same config, mem_ack delayed 3 cycles per request -> mem_addr stable while unacked; identical address sequence.
REQ-024 store=0, m=2,k=2 -> no mem_we=1 cycles; tile_done one cycle after arr_done.
REQ-025 m=0,k=4 -> no A reads, 4 B reads, no writes even with store=1.
REQ-026 A=0xFFFF_FFC0, strideA=0x40, m=2 -> addresses 0xFFFF_FFC0, 0x0000_0000.
REQ-027 Two configs queued back-to-back -> two read_all_buffers pulses, two tile_done pulses; rst asserted during FETCH_B of second -> all outputs zero, no second tile_done.
